// File: rtl/powerup_pkg.sv
// rtl/powerup_pkg.sv - shared constants, types and helpers for the power-up pool
package powerup_pkg;

    localparam int PU_TYPE_W = 2;

    localparam logic [9:0] OFFSCREEN_X = 10'd679;
    localparam logic [9:0] OFFSCREEN_Y = 10'd0;

    typedef enum logic [PU_TYPE_W-1:0] {
        PU_SPEED,
        PU_SHIELD,
        PU_SPREAD,
        PU_LIFE
    } pu_type_e;

    typedef struct packed {
        logic       exists;
        logic [9:0] x;
        logic [9:0] y;
        pu_type_e   kind;
    } pu_slot_t;

    // Keeps a spawn fully on screen by pulling its left edge back to max_x.
    function automatic logic [9:0] clamp_x(input logic [9:0] x, input logic [9:0] max_x);
        return (x > max_x) ? max_x : x;
    endfunction

endpackage

// File: rtl/powerup_slot.sv
// rtl/powerup_slot.sv - one falling power-up: position, type, ship overlap and bottom detection
module powerup_slot
    import powerup_pkg::*;
#(
    parameter int TYPE_W     = 2,
    parameter int FALL_SPEED = 2,
    parameter int PU_W       = 7,
    parameter int PU_H       = 7,
    parameter int SHIP_W     = 30,
    parameter int SHIP_H     = 30,
    parameter int SPAWN_Y    = 5,
    parameter int BOTTOM_Y   = 476
) (
    input  logic              frame_clk,
    input  logic              Reset,
    input  logic              pause,
    input  logic              load,
    input  logic [9:0]        load_x,
    input  logic [TYPE_W-1:0] load_type,
    input  logic [9:0]        ship_x,
    input  logic [9:0]        ship_y,
    output logic [9:0]        pos_x,
    output logic [9:0]        pos_y,
    output logic [TYPE_W-1:0] kind,
    output logic              exists,
    output logic              hit,
    output logic              miss
);

    localparam logic [10:0] SHIP_W11   = 11'(SHIP_W);
    localparam logic [10:0] SHIP_H11   = 11'(SHIP_H);
    localparam logic [10:0] PU_W11     = 11'(PU_W);
    localparam logic [10:0] PU_H11     = 11'(PU_H);
    localparam logic [10:0] FALL_11    = 11'(FALL_SPEED);
    localparam logic [10:0] BOTTOM_11  = 11'(BOTTOM_Y);
    localparam logic [9:0]  FALL_10    = 10'(FALL_SPEED);
    localparam logic [9:0]  SPAWN_Y10  = 10'(SPAWN_Y);

    logic [10:0] px, py, sx, sy, next_y;
    logic        overlap;

    // Overlap and bottom tests in 11 bits so edge sums near 1023 cannot wrap.
    always_comb begin
        px      = {1'b0, pos_x};
        py      = {1'b0, pos_y};
        sx      = {1'b0, ship_x};
        sy      = {1'b0, ship_y};
        next_y  = py + FALL_11;
        overlap = (px < sx + SHIP_W11) && (px + PU_W11 > sx) &&
                  (py < sy + SHIP_H11) && (py + PU_H11 > sy);
        hit     = exists && !pause && overlap;
        miss    = exists && !pause && !overlap && (next_y >= BOTTOM_11);
    end

    // Slot state: load only ever targets a free slot, so it cannot race a hit or miss.
    always_ff @(posedge frame_clk or negedge Reset) begin
        if (!Reset) begin
            exists <= 1'b0;
            pos_x  <= OFFSCREEN_X;
            pos_y  <= OFFSCREEN_Y;
            kind   <= '0;
        end else if (load) begin
            exists <= 1'b1;
            pos_x  <= load_x;
            pos_y  <= SPAWN_Y10;
            kind   <= load_type;
        end else if (hit || miss) begin
            exists <= 1'b0;
            pos_x  <= OFFSCREEN_X;
            pos_y  <= OFFSCREEN_Y;
        end else if (exists && !pause) begin
            pos_y  <= pos_y + FALL_10;
        end
    end

endmodule

// File: rtl/powerup_pool.sv
// rtl/powerup_pool.sv - pool of falling power-ups with spawn allocation and pickup/miss reporting
module powerup_pool
    import powerup_pkg::*;
#(
    parameter int NUM_SLOTS  = 4,
    parameter int TYPE_W     = 2,
    parameter int FALL_SPEED = 2,
    parameter int PU_W       = 7,
    parameter int PU_H       = 7,
    parameter int SHIP_W     = 30,
    parameter int SHIP_H     = 30,
    parameter int SPAWN_Y    = 5,
    parameter int BOTTOM_Y   = 476,
    parameter int SCREEN_W   = 640
) (
    input  logic                        frame_clk,
    input  logic                        Reset,
    input  logic                        pause,
    input  logic                        generate_powerup,
    input  logic [9:0]                  spawn_x,
    input  logic [TYPE_W-1:0]           spawn_type,
    input  logic [9:0]                  ShipX,
    input  logic [9:0]                  ShipY,
    output logic [NUM_SLOTS*10-1:0]     PowerupX,
    output logic [NUM_SLOTS*10-1:0]     PowerupY,
    output logic [NUM_SLOTS*TYPE_W-1:0] powerup_type,
    output logic [NUM_SLOTS-1:0]        powerup_exists,
    output logic                        got_powerup,
    output logic [TYPE_W-1:0]           got_type,
    output logic                        missed_powerup,
    output logic                        spawn_dropped
);

    localparam logic [9:0] MAX_X = 10'(SCREEN_W - PU_W);

    logic [NUM_SLOTS-1:0] load_v, hit_v, miss_v;
    logic                 any_free, hit_found;
    logic [TYPE_W-1:0]    hit_kind;
    logic [9:0]           spawn_x_clamped;

    assign spawn_x_clamped = clamp_x(spawn_x, MAX_X);

    // Lowest free slot (as registered at the start of the frame) takes the spawn; lowest hit names the pickup.
    always_comb begin
        load_v    = '0;
        any_free  = 1'b0;
        hit_found = 1'b0;
        hit_kind  = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!powerup_exists[i] && !any_free) begin
                load_v[i] = generate_powerup;
                any_free  = 1'b1;
            end
            if (hit_v[i] && !hit_found) begin
                hit_kind  = powerup_type[TYPE_W*i +: TYPE_W];
                hit_found = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        powerup_slot #(
            .TYPE_W    (TYPE_W),
            .FALL_SPEED(FALL_SPEED),
            .PU_W      (PU_W),
            .PU_H      (PU_H),
            .SHIP_W    (SHIP_W),
            .SHIP_H    (SHIP_H),
            .SPAWN_Y   (SPAWN_Y),
            .BOTTOM_Y  (BOTTOM_Y)
        ) u_slot (
            .frame_clk(frame_clk),
            .Reset    (Reset),
            .pause    (pause),
            .load     (load_v[g]),
            .load_x   (spawn_x_clamped),
            .load_type(spawn_type),
            .ship_x   (ShipX),
            .ship_y   (ShipY),
            .pos_x    (PowerupX[10*g +: 10]),
            .pos_y    (PowerupY[10*g +: 10]),
            .kind     (powerup_type[TYPE_W*g +: TYPE_W]),
            .exists   (powerup_exists[g]),
            .hit      (hit_v[g]),
            .miss     (miss_v[g])
        );
    end

    // One-frame event pulses; got_type keeps the last pickup between pulses.
    always_ff @(posedge frame_clk or negedge Reset) begin
        if (!Reset) begin
            got_powerup    <= 1'b0;
            got_type       <= '0;
            missed_powerup <= 1'b0;
            spawn_dropped  <= 1'b0;
        end else begin
            got_powerup    <= hit_found;
            if (hit_found) begin
                got_type   <= hit_kind;
            end
            missed_powerup <= |miss_v;
            spawn_dropped  <= generate_powerup && !any_free;
        end
    end

endmodule

// File: tb/tb_powerup_pool.sv
// tb/tb_powerup_pool.sv - scoreboard bench for powerup_pool
module tb_powerup_pool;
    import powerup_pkg::*;

    localparam int N = 4;

    logic            frame_clk = 1'b0;
    logic            Reset = 1'b1;
    logic            pause = 1'b0;
    logic            generate_powerup = 1'b0;
    logic [9:0]      spawn_x = '0;
    logic [1:0]      spawn_type = '0;
    logic [9:0]      ShipX = 10'd600;
    logic [9:0]      ShipY = 10'd400;
    logic [N*10-1:0] PowerupX, PowerupY;
    logic [N*2-1:0]  powerup_type;
    logic [N-1:0]    powerup_exists;
    logic            got_powerup, missed_powerup, spawn_dropped;
    logic [1:0]      got_type;

    powerup_pool dut (
        .frame_clk       (frame_clk),
        .Reset           (Reset),
        .pause           (pause),
        .generate_powerup(generate_powerup),
        .spawn_x         (spawn_x),
        .spawn_type      (spawn_type),
        .ShipX           (ShipX),
        .ShipY           (ShipY),
        .PowerupX        (PowerupX),
        .PowerupY        (PowerupY),
        .powerup_type    (powerup_type),
        .powerup_exists  (powerup_exists),
        .got_powerup     (got_powerup),
        .got_type        (got_type),
        .missed_powerup  (missed_powerup),
        .spawn_dropped   (spawn_dropped)
    );

    always #5 frame_clk = ~frame_clk;

    typedef struct packed {
        logic [N-1:0]    ex;
        logic [N*10-1:0] x;
        logic [N*10-1:0] y;
        logic [N*2-1:0]  ty;
        logic [4:0]      pl;
    } exp_t;

    exp_t     sb[$];
    int       checks = 0;
    int       errors = 0;
    pu_slot_t m_s[N];
    logic     m_got, m_miss, m_drop;
    logic [1:0] m_gt;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_s[i].exists = 1'b0;
            m_s[i].x      = 10'd679;
            m_s[i].y      = 10'd0;
            m_s[i].kind   = PU_SPEED;
        end
        m_got = 1'b0; m_miss = 1'b0; m_drop = 1'b0; m_gt = 2'd0;
    endtask

    task automatic model_frame();
        logic was_free[N];
        int   px, py, sx, sy;
        bit   ov, placed;
        for (int i = 0; i < N; i++) was_free[i] = !m_s[i].exists;
        m_got = 1'b0; m_miss = 1'b0; m_drop = 1'b0;
        if (!pause) begin
            for (int i = 0; i < N; i++) begin
                if (m_s[i].exists) begin
                    px = int'(m_s[i].x); py = int'(m_s[i].y);
                    sx = int'(ShipX);    sy = int'(ShipY);
                    ov = (px < sx + 30) && (px + 7 > sx) && (py < sy + 30) && (py + 7 > sy);
                    if (ov) begin
                        if (!m_got) m_gt = m_s[i].kind;
                        m_got = 1'b1;
                        m_s[i].exists = 1'b0; m_s[i].x = 10'd679; m_s[i].y = 10'd0;
                    end else if (py + 2 >= 476) begin
                        m_miss = 1'b1;
                        m_s[i].exists = 1'b0; m_s[i].x = 10'd679; m_s[i].y = 10'd0;
                    end else begin
                        m_s[i].y = 10'(py + 2);
                    end
                end
            end
        end
        if (generate_powerup) begin
            placed = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (was_free[i] && !placed) begin
                    placed = 1'b1;
                    m_s[i].exists = 1'b1;
                    m_s[i].x      = (spawn_x > 10'd633) ? 10'd633 : spawn_x;
                    m_s[i].y      = 10'd5;
                    m_s[i].kind   = pu_type_e'(spawn_type);
                end
            end
            if (!placed) m_drop = 1'b1;
        end
    endtask

    // Advance the model, queue its prediction, clock the DUT and compare once outputs settle.
    task automatic step();
        exp_t e;
        exp_t got;
        logic [N*2-1:0] tmask;
        if (!Reset) model_reset(); else model_frame();
        for (int i = 0; i < N; i++) begin
            e.ex[i]        = m_s[i].exists;
            e.x[10*i +: 10] = m_s[i].x;
            e.y[10*i +: 10] = m_s[i].y;
            e.ty[2*i +: 2]  = m_s[i].kind;
        end
        e.pl = {m_got, m_gt, m_miss, m_drop};
        sb.push_back(e);
        @(posedge frame_clk);
        #1;
        got = sb.pop_front();
        for (int i = 0; i < N; i++) tmask[2*i +: 2] = {2{got.ex[i]}};
        checks++;
        if (powerup_exists !== got.ex) begin
            errors++;
            $display("FAIL sb_exists t=%0t got %b want %b", $time, powerup_exists, got.ex);
        end
        checks++;
        if (PowerupX !== got.x) begin
            errors++;
            $display("FAIL sb_x t=%0t got %h want %h", $time, PowerupX, got.x);
        end
        checks++;
        if (PowerupY !== got.y) begin
            errors++;
            $display("FAIL sb_y t=%0t got %h want %h", $time, PowerupY, got.y);
        end
        checks++;
        if ((powerup_type & tmask) !== (got.ty & tmask)) begin
            errors++;
            $display("FAIL sb_type t=%0t got %b want %b", $time, powerup_type & tmask, got.ty & tmask);
        end
        checks++;
        if ({got_powerup, got_type, missed_powerup, spawn_dropped} !== got.pl) begin
            errors++;
            $display("FAIL sb_pulses t=%0t got %b want %b", $time,
                     {got_powerup, got_type, missed_powerup, spawn_dropped}, got.pl);
        end
    endtask

    task automatic spawn(input logic [9:0] x, input logic [1:0] t);
        generate_powerup = 1'b1; spawn_x = x; spawn_type = t;
        step();
        generate_powerup = 1'b0;
    endtask

    task automatic test_reset();
        #1 Reset = 1'b0;
        model_reset();
        step();
        step();
        checks++;
        if (powerup_exists !== 4'b0000 || PowerupX !== {4{10'd679}} || PowerupY !== '0 || powerup_type !== '0) begin
            errors++;
            $display("FAIL reset_state got ex=%b x=%h y=%h want ex=0 x=all 679 y=0", powerup_exists, PowerupX, PowerupY);
        end
        checks++;
        if ({got_powerup, got_type, missed_powerup, spawn_dropped} !== 5'b0) begin
            errors++;
            $display("FAIL reset_pulses got %b want 0", {got_powerup, got_type, missed_powerup, spawn_dropped});
        end
        Reset = 1'b1;
    endtask

    task automatic test_reset_mid_fall();
        ShipX = 10'd300; ShipY = 10'd200;
        spawn(10'd100, 2'd2);
        repeat (97) step();
        #2 Reset = 1'b0;
        #1;
        checks++;
        if (powerup_exists[0] !== 1'b0 || PowerupX[9:0] !== 10'd679 || PowerupY[9:0] !== 10'd0) begin
            errors++;
            $display("FAIL async_reset got ex=%b x=%0d y=%0d want 0 679 0", powerup_exists[0], PowerupX[9:0], PowerupY[9:0]);
        end
        checks++;
        if ({got_powerup, missed_powerup, spawn_dropped} !== 3'b0) begin
            errors++;
            $display("FAIL async_reset_pulses got %b want 000", {got_powerup, missed_powerup, spawn_dropped});
        end
        model_reset();
        step();
        Reset = 1'b1;
    endtask

    task automatic test_fall_miss();
        int n;
        logic [9:0] last_y;
        ShipX = 10'd300; ShipY = 10'd200;
        spawn(10'd100, PU_SPREAD);
        checks++;
        if (PowerupX[9:0] !== 10'd100 || PowerupY[9:0] !== 10'd5 || powerup_type[1:0] !== 2'd2) begin
            errors++;
            $display("FAIL spawn_pos got x=%0d y=%0d t=%0d want 100 5 2", PowerupX[9:0], PowerupY[9:0], powerup_type[1:0]);
        end
        step();
        checks++;
        if (PowerupY[9:0] !== 10'd7) begin
            errors++;
            $display("FAIL first_move got %0d want 7", PowerupY[9:0]);
        end
        n = 0;
        last_y = PowerupY[9:0];
        while (n < 300 && !missed_powerup) begin
            last_y = PowerupY[9:0];
            step();
            n++;
        end
        checks++;
        if (n !== 235 || last_y !== 10'd475) begin
            errors++;
            $display("FAIL miss_frame got n=%0d lastY=%0d want n=235 lastY=475", n, last_y);
        end
        checks++;
        if (powerup_exists[0] !== 1'b0 || PowerupX[9:0] !== 10'd679 || PowerupY[9:0] !== 10'd0) begin
            errors++;
            $display("FAIL miss_free got ex=%b x=%0d y=%0d want 0 679 0", powerup_exists[0], PowerupX[9:0], PowerupY[9:0]);
        end
        step();
        checks++;
        if (missed_powerup !== 1'b0) begin
            errors++;
            $display("FAIL miss_width got %b want 0", missed_powerup);
        end
    endtask

    task automatic test_pickup();
        int n;
        logic [9:0] prev_y;
        ShipX = 10'd90; ShipY = 10'd300;
        spawn(10'd100, PU_SPREAD);
        n = 0;
        prev_y = PowerupY[9:0];
        while (n < 200 && !got_powerup) begin
            prev_y = PowerupY[9:0];
            step();
            n++;
        end
        checks++;
        if (got_powerup !== 1'b1 || prev_y !== 10'd295 || got_type !== 2'd2 || powerup_exists[0] !== 1'b0) begin
            errors++;
            $display("FAIL pickup got g=%b prevY=%0d t=%0d ex=%b want 1 295 2 0", got_powerup, prev_y, got_type, powerup_exists[0]);
        end
        step();
        checks++;
        if (got_powerup !== 1'b0 || got_type !== 2'd2) begin
            errors++;
            $display("FAIL pickup_hold got g=%b t=%0d want 0 2", got_powerup, got_type);
        end
    endtask

    task automatic test_fill();
        logic [9:0] xs [5];
        logic [1:0] ts [5];
        logic [3:0] want_ex;
        xs = '{10'd10, 10'd200, 10'd400, 10'd500, 10'd300};
        ts = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
        ShipX = 10'd600; ShipY = 10'd400;
        generate_powerup = 1'b1;
        for (int k = 0; k < 5; k++) begin
            spawn_x = xs[k]; spawn_type = ts[k];
            step();
            want_ex = (k < 4) ? 4'((1 << (k + 1)) - 1) : 4'hf;
            checks++;
            if (powerup_exists !== want_ex || spawn_dropped !== (k == 4)) begin
                errors++;
                $display("FAIL fill_%0d got ex=%b drop=%b want ex=%b drop=%0d", k, powerup_exists, spawn_dropped, want_ex, k == 4);
            end
        end
        generate_powerup = 1'b0;
        step();
        checks++;
        if (spawn_dropped !== 1'b0) begin
            errors++;
            $display("FAIL drop_width got %b want 0", spawn_dropped);
        end
    endtask

    task automatic test_collide_spawn();
        ShipX = 10'd190; ShipY = 10'(int'(m_s[1].y) - 5);
        generate_powerup = 1'b1; spawn_x = 10'd300; spawn_type = 2'd3;
        step();
        checks++;
        if (spawn_dropped !== 1'b1 || got_powerup !== 1'b1 || got_type !== 2'd1 || powerup_exists !== 4'b1101) begin
            errors++;
            $display("FAIL collide_spawn got drop=%b g=%b t=%0d ex=%b want 1 1 1 1101", spawn_dropped, got_powerup, got_type, powerup_exists);
        end
        ShipX = 10'd600; ShipY = 10'd400;
        step();
        generate_powerup = 1'b0;
        checks++;
        if (powerup_exists !== 4'hf || spawn_dropped !== 1'b0 || PowerupX[19:10] !== 10'd300 || powerup_type[3:2] !== 2'd3) begin
            errors++;
            $display("FAIL slot1_reuse got ex=%b drop=%b x=%0d t=%0d want f 0 300 3", powerup_exists, spawn_dropped, PowerupX[19:10], powerup_type[3:2]);
        end
        Reset = 1'b0;
        step();
        Reset = 1'b1;
    endtask

    task automatic test_pause();
        ShipX = 10'd90; ShipY = 10'd0;
        spawn(10'd100, PU_SHIELD);
        pause = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) spawn(10'd400, 2'd0); else step();
            checks++;
            if (PowerupY[9:0] !== 10'd5 || got_powerup !== 1'b0) begin
                errors++;
                $display("FAIL pause_%0d got y=%0d g=%b want 5 0", k, PowerupY[9:0], got_powerup);
            end
        end
        checks++;
        if (powerup_exists !== 4'b0011) begin
            errors++;
            $display("FAIL pause_spawn got %b want 0011", powerup_exists);
        end
        pause = 1'b0;
        step();
        checks++;
        if (got_powerup !== 1'b1 || got_type !== 2'd1 || powerup_exists[0] !== 1'b0 || PowerupY[19:10] !== 10'd7) begin
            errors++;
            $display("FAIL unpause got g=%b t=%0d ex0=%b y1=%0d want 1 1 0 7", got_powerup, got_type, powerup_exists[0], PowerupY[19:10]);
        end
    endtask

    task automatic test_clamp();
        ShipX = 10'd600; ShipY = 10'd400;
        spawn(10'd700, 2'd3);
        checks++;
        if (PowerupX[9:0] !== 10'd633) begin
            errors++;
            $display("FAIL clamp_700 got %0d want 633", PowerupX[9:0]);
        end
        spawn(10'd633, 2'd0);
        spawn(10'd632, 2'd1);
        checks++;
        if (PowerupX[29:20] !== 10'd633 || PowerupX[39:30] !== 10'd632) begin
            errors++;
            $display("FAIL clamp_edge got %0d %0d want 633 632", PowerupX[29:20], PowerupX[39:30]);
        end
        repeat (3) step();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_reset_mid_fall();
        test_fall_miss();
        test_pickup();
        test_fill();
        test_collide_spawn();
        test_pause();
        test_clamp();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
